// File: rtl/gen_frecuencia_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gen_frecuencia_if : control/status bundle of the square-wave generator    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface gen_frecuencia_if;
  logic       en_i;
  logic [2:0] sel_i;
  logic       clk_o;
  logic       tick_o;
  logic [2:0] sel_act_o;

  modport master (
    output en_i, sel_i,
    input  clk_o, tick_o, sel_act_o
  );

  modport slave (
    input  en_i, sel_i,
    output clk_o, tick_o, sel_act_o
  );
endinterface
`default_nettype wire

// File: rtl/gen_frecuencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gen_frecuencia : programmable 50%-duty square wave, index 0 (slow)..7     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module gen_frecuencia #(
  parameter int DIV_BASE = 50000,
  parameter int CNT_W    = 24
) (
  input  logic            clk_i,
  input  logic            reset,
  gen_frecuencia_if.slave bus
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  localparam logic [CNT_W-1:0] C_BASE = CNT_W'(DIV_BASE);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  phase_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic [2:0]         sel_act_q, sel_act_d;
  logic [CNT_W-1:0]   w_half;
  logic               w_last;

  // CNT_W is sized so the largest shift (index 0) never truncates.
  assign w_half = C_BASE << (3'd7 - sel_act_q);
  assign w_last = (cnt_q == (w_half - C_ONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    sel_act_d = sel_act_q;
    if (!bus.en_i) begin
      state_d   = PH_LOW;
      cnt_d     = '0;
      clk_d     = 1'b0;
      sel_act_d = bus.sel_i;
    end else if (!w_last) begin
      cnt_d = cnt_q + C_ONE;
    end else begin
      cnt_d = '0;
      if (state_q == PH_LOW) begin
        state_d = PH_HIGH;
        clk_d   = 1'b1;
        tick_d  = 1'b1;
      end else begin
        // Period boundary: only point where a new index may take effect.
        state_d   = PH_LOW;
        clk_d     = 1'b0;
        sel_act_d = bus.sel_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q   <= PH_LOW;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      sel_act_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      sel_act_q <= sel_act_d;
    end
  end

  assign bus.clk_o     = clk_q;
  assign bus.tick_o    = tick_q;
  assign bus.sel_act_o = sel_act_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_frecuencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gen_frecuencia : directed + random bench with period-position model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_gen_frecuencia;

  localparam int BASE  = 2;
  localparam int LIMIT = 2000;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  gen_frecuencia_if bus ();

  gen_frecuencia #(.DIV_BASE(BASE), .CNT_W(12)) u_dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Model: position inside the current period; high half is the second half.
  int         m_pos  = 0;
  logic [2:0] m_sel  = 3'd0;
  logic       m_clk  = 1'b0;
  logic       m_tick = 1'b0;

  function automatic int m_half();
    return BASE * (1 << (7 - int'(m_sel)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_update();
    if (reset) begin
      m_pos = 0; m_sel = 3'd0; m_clk = 1'b0; m_tick = 1'b0;
    end else if (!bus.en_i) begin
      m_pos = 0; m_sel = bus.sel_i; m_clk = 1'b0; m_tick = 1'b0;
    end else begin
      m_pos++;
      m_tick = (m_pos == m_half());
      if (m_pos == 2 * m_half()) begin
        m_pos = 0;
        m_sel = bus.sel_i;
      end
      m_clk = (m_pos >= m_half());
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    m_update();
    #1;
    chk("clk_o",     {31'd0, bus.clk_o},  {31'd0, m_clk});
    chk("tick_o",    {31'd0, bus.tick_o}, {31'd0, m_tick});
    chk("sel_act_o", {29'd0, bus.sel_act_o}, {29'd0, m_sel});
  endtask

  // Steps until clk_o reaches the given level; returns number of edges taken.
  task automatic run_until_clk(input logic lvl, input string tag, output int n);
    n = 0;
    while (bus.clk_o !== lvl && n < LIMIT) begin
      step();
      n++;
    end
    if (bus.clk_o !== lvl) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n, ticks, lo, hi;
    bus.en_i  = 1'b0;
    bus.sel_i = 3'd7;
    repeat (2) step();
    #2;
    chk("reset_clk",  {31'd0, bus.clk_o}, 32'd0);
    chk("reset_tick", {31'd0, bus.tick_o}, 32'd0);
    chk("reset_sel",  {29'd0, bus.sel_act_o}, 32'd0);
    reset = 1'b0;

    // Load index 7 in idle, run until clk_o=1 with div_cnt=1, then async reset.
    step();
    bus.en_i = 1'b1;
    repeat (3) step();
    chk("pre_reset_clk", {31'd0, bus.clk_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_clk",  {31'd0, bus.clk_o}, 32'd0);
    chk("async_tick", {31'd0, bus.tick_o}, 32'd0);
    chk("async_sel",  {29'd0, bus.sel_act_o}, 32'd0);
    m_pos = 0; m_sel = 3'd0; m_clk = 1'b0; m_tick = 1'b0;
    #1 reset = 1'b0;

    // Index 7: period 4, one tick per rise.
    bus.en_i = 1'b0; step();
    bus.en_i = 1'b1;
    ticks = 0;
    repeat (16) begin step(); ticks += int'(bus.tick_o); end
    chk("idx7_ticks", ticks, 32'd4);

    // Index 0: period 512, four ticks over four periods.
    bus.en_i = 1'b0; bus.sel_i = 3'd0; step();
    bus.en_i = 1'b1;
    ticks = 0;
    repeat (2048) begin step(); ticks += int'(bus.tick_o); end
    chk("idx0_ticks", ticks, 32'd4);

    // Change 0 -> 7 mid low-half; old period must finish at 512.
    bus.en_i = 1'b0; step();
    bus.en_i = 1'b1;
    repeat (100) step();
    bus.sel_i = 3'd7;
    n = 100;
    while (bus.sel_act_o !== 3'd7 && n < LIMIT) begin step(); n++; end
    chk("switch_edge", n, 32'd512);
    run_until_clk(1'b1, "switch_lo", lo);
    run_until_clk(1'b0, "switch_hi", hi);
    chk("switch_lo", lo, 32'd2);
    chk("switch_hi", hi, 32'd2);

    // Drop enable in the high half, then re-enable at index 5.
    run_until_clk(1'b1, "drop_wait", n);
    bus.en_i = 1'b0; bus.sel_i = 3'd5;
    step();
    chk("drop_clk", {31'd0, bus.clk_o}, 32'd0);
    chk("drop_sel", {29'd0, bus.sel_act_o}, 32'd5);
    bus.en_i = 1'b1;
    run_until_clk(1'b1, "reen", n);
    chk("reen_rise", n, 32'd8);

    // Sweep 7 -> 0, one step per period.
    bus.en_i = 1'b0; bus.sel_i = 3'd7; step();
    bus.en_i = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      run_until_clk(1'b1, "sweep_lo", lo);
      if (k > 0) bus.sel_i = 3'(k - 1);
      run_until_clk(1'b0, "sweep_hi", hi);
      chk($sformatf("sweep_lo%0d", k), lo, BASE << (7 - k));
      chk($sformatf("sweep_hi%0d", k), hi, BASE << (7 - k));
    end

    // Random enable/index activity against the model.
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) bus.sel_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) bus.en_i = ~bus.en_i;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
